// File: rtl/rgstr_wr_arb.sv
// Round-robin write arbiter that shares a register bank between NREQ requesters,
// with optional owner-locked bursts capped at MAXBURST grants before rotation.
module rgstr_wr_arb #(
    parameter int WIDTH    = 32,
    parameter int NREQ     = 4,
    parameter int NREG     = 8,
    parameter int MAXBURST = 4,
    localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NREQ-1:0]         Req,
    input  logic [NREQ-1:0]         Lock,
    input  logic [NREQ*AW-1:0]      Addr,
    input  logic [NREQ*WIDTH-1:0]   Data,
    output logic [NREQ-1:0]         Gnt,
    output logic [NREG-1:0]         En,
    output logic [WIDTH-1:0]        N,
    output logic                    Err,
    output logic                    Busy
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBURST + 1);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           r_state, w_nxt_state;
    logic [PW-1:0]    r_ptr, r_owner, w_nxt_ptr, w_nxt_owner;
    logic [PW-1:0]    w_base, w_idx, w_j;
    logic [CW-1:0]    r_cnt, w_nxt_cnt;
    logic             w_vld, w_own_req;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic [NREG-1:0]  r_en;
    logic [WIDTH-1:0] r_n;
    logic             r_err, r_busy;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A burst owner whose request has dropped hands the cycle back to normal
    // rotation starting just after it, so the abort cycle still carries a grant.
    always_comb begin
        w_own_req = (r_state == S_BURST) && Req[r_owner];
        w_base    = (r_state == S_BURST) ? inc_ptr(r_owner) : r_ptr;
        w_vld     = 1'b0;
        w_idx     = r_owner;
        w_j       = '0;
        if (w_own_req) begin
            w_vld = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                w_j = PW'((int'(w_base) + k) % NREQ);
                if (!w_vld && Req[w_j]) begin
                    w_vld = 1'b1;
                    w_idx = w_j;
                end
            end
        end
    end

    assign Gnt    = (w_vld && !Rst) ? (NREQ'(1) << w_idx) : '0;
    assign w_addr = Addr[int'(w_idx)*AW +: AW];
    assign w_data = Data[int'(w_idx)*WIDTH +: WIDTH];

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_owner = r_owner;
        w_nxt_cnt   = r_cnt;
        if (w_own_req) begin
            if (r_cnt == CW'(MAXBURST - 1) || !Lock[r_owner]) begin
                w_nxt_state = S_IDLE;
                w_nxt_ptr   = w_base;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt = r_cnt + 1'b1;
            end
        end else if (w_vld && Lock[w_idx] && MAXBURST > 1) begin
            w_nxt_state = S_BURST;
            w_nxt_owner = w_idx;
            w_nxt_cnt   = CW'(1);
            w_nxt_ptr   = w_base;
        end else begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_ptr   = w_vld ? inc_ptr(w_idx) : w_base;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_en    <= '0;
            r_n     <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_owner <= w_nxt_owner;
            r_cnt   <= w_nxt_cnt;
            r_busy  <= (w_nxt_state == S_BURST);
            r_en    <= '0;
            r_err   <= 1'b0;
            // Out-of-range writes are consumed but flagged instead of enabled.
            if (w_vld) begin
                r_n <= w_data;
                if (int'(w_addr) < NREG) begin
                    r_en <= NREG'(1) << w_addr;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign En   = r_en;
    assign N    = r_n;
    assign Err  = r_err;
    assign Busy = r_busy;

endmodule

// File: tb/tb_rgstr_wr_arb.sv
// Bench for rgstr_wr_arb: directed scenarios followed by random traffic,
// every cycle compared against a behavioural arbitration model.
module tb_rgstr_wr_arb;
    localparam int WIDTH    = 32;
    localparam int NREQ     = 4;
    localparam int NREG     = 6;
    localparam int MAXBURST = 4;
    localparam int AW       = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       lock = '0;
    logic [AW-1:0]         addr [NREQ];
    logic [WIDTH-1:0]      data [NREQ];
    logic [NREQ*AW-1:0]    addr_f;
    logic [NREQ*WIDTH-1:0] data_f;
    logic [NREQ-1:0]       gnt;
    logic [NREG-1:0]       en;
    logic [WIDTH-1:0]      n;
    logic                  err, busy;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int              m_ptr, m_owner, m_cnt, m_lastg;
    bit              m_burst;
    logic [NREG-1:0] e_en;
    logic [WIDTH-1:0] e_n;
    logic            e_err, e_busy;
    logic [NREQ-1:0] last_gnt;
    logic [NREQ-1:0] gseq [6];
    bit              pend [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        addr_f = '0;
        data_f = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_f[i*AW +: AW]       = addr[i];
            data_f[i*WIDTH +: WIDTH] = data[i];
        end
    end

    rgstr_wr_arb #(
        .WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .MAXBURST(MAXBURST)
    ) dut (
        .Clk(clk), .Rst(rst), .Req(req), .Lock(lock), .Addr(addr_f), .Data(data_f),
        .Gnt(gnt), .En(en), .N(n), .Err(err), .Busy(busy)
    );

    function automatic int model_grant();
        int base;
        if (rst) return -1;
        if (m_burst && req[2'(m_owner)]) return m_owner;
        base = m_burst ? (m_owner + 1) % NREQ : m_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (req[2'((base + k) % NREQ)]) return (base + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 0;
        e_en = '0; e_n = '0; e_err = 1'b0; e_busy = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        int g, base;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        g  = model_grant();
        eg = (g < 0) ? '0 : (NREQ'(1) << g);
        last_gnt = gnt;
        m_lastg  = g;
        chk("gnt",  64'(gnt),  64'(eg));
        chk("en",   64'(en),   64'(e_en));
        chk("n",    64'(n),    64'(e_n));
        chk("err",  64'(err),  64'(e_err));
        chk("busy", 64'(busy), 64'(e_busy));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                e_n   = data[2'(g)];
                e_err = (int'(addr[2'(g)]) >= NREG);
                e_en  = e_err ? '0 : (NREG'(1) << addr[2'(g)]);
            end else begin
                e_en  = '0;
                e_err = 1'b0;
            end
            if (m_burst && req[2'(m_owner)]) begin
                m_cnt++;
                if (m_cnt == MAXBURST || !lock[2'(m_owner)]) begin
                    m_burst = 0;
                    m_ptr   = (m_owner + 1) % NREQ;
                end
            end else begin
                base = m_burst ? (m_owner + 1) % NREQ : m_ptr;
                if (g >= 0 && lock[2'(g)] && MAXBURST > 1) begin
                    m_burst = 1; m_owner = g; m_cnt = 1; m_ptr = base;
                end else begin
                    m_burst = 0;
                    m_ptr   = (g >= 0) ? (g + 1) % NREQ : base;
                end
            end
            e_busy = m_burst;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            addr[i] = AW'(i);
            data[i] = 32'hA000_0000 + i;
            pend[i] = 0;
        end
        req = 4'b1111;
        model_reset();
        @(posedge clk);
        #1;
        // reset held with all requests pending
        step();
        step();
        rst = 1'b0;
        step();
        chk("first_gnt", 64'(last_gnt), 64'(4'b0001));

        // plain rotation
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rot_gnt", 64'(last_gnt), 64'(4'b0001 << ((k + 1) % 4)));
        end

        // write path
        req = 4'b0100; addr[2] = 3'd5; data[2] = 32'hFFFF_FFFF;
        step();
        chk("wr_en", 64'(en), 64'(6'b10_0000));
        chk("wr_n",  64'(n),  64'(32'hFFFF_FFFF));
        req = 4'b0000;
        step();

        // burst cap: move pointer to requester 1, then lock it
        req = 4'b0001;
        step();
        req = 4'b1111; lock = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            step();
            gseq[k] = last_gnt;
        end
        chk("cap_g0", 64'(gseq[0]), 64'(4'b0010));
        chk("cap_g3", 64'(gseq[3]), 64'(4'b0010));
        chk("cap_g4", 64'(gseq[4]), 64'(4'b0100));

        // burst abort after the owner's second grant
        req = 4'b0001; lock = 4'b0000;
        step();
        req = 4'b1111; lock = 4'b0010;
        step();
        step();
        chk("abort_busy_on", 64'(busy), 64'(1'b1));
        req = 4'b1101;
        step();
        chk("abort_gnt",  64'(last_gnt), 64'(4'b0100));
        chk("abort_busy", 64'(busy),     64'(1'b0));

        // out-of-range address
        req = 4'b0001; lock = 4'b0000; addr[0] = 3'd7;
        step();
        chk("bad_en",  64'(en),  64'(6'b0));
        chk("bad_err", 64'(err), 64'(1'b1));
        req = 4'b0000;
        step();
        chk("bad_err_clr", 64'(err), 64'(1'b0));

        // reset in the middle of a burst
        req = 4'b1111; lock = 4'b0010;
        step();
        rst = 1'b1;
        step();
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_en",   64'(en),   64'(6'b0));
        chk("rst_n",    64'(n),    64'(32'h0));
        rst = 1'b0;

        // random traffic
        req = '0; lock = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 0;
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    addr[i] = AW'($urandom_range(0, 7));
                    data[i] = $urandom;
                end
                req[i]  = pend[i];
                lock[i] = ($urandom_range(0, 2) == 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            if (m_lastg >= 0 && !rst) pend[m_lastg] = 0;
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
